// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
// Contents:
//   state_e         controller FSM states (IDLE, ACCESS, DONE)
//   ADDR_BASE_DEF   default byte address mapped to SRAM word 0
//   WAIT_CYCLES_DEF default number of SRAM access cycles per transaction
//   CNT_W           width of the wait-state counter (covers 1..15 wait cycles)
//   STROBE_ON/OFF   levels of the active-low SRAM strobes
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [31:0] ADDR_BASE_DEF   = 32'd1024;
  localparam int unsigned WAIT_CYCLES_DEF = 5;
  localparam int unsigned CNT_W           = 4;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the SRAM wait states.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val (has priority over en)
//   en          decrement by one; holds at zero
//   load_val    value loaded on load
//   cnt         current count
//   zero        cnt == 0
module mem_wait_counter
  import arm_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller for an external asynchronous SRAM.
// Accepts a load/store from the EXE/MEM register, runs a multi-cycle SRAM
// access with WAIT_CYCLES wait states and holds ready low (pipeline freeze)
// until the access has completed.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   Mem_R_EN, Mem_W_EN    load / store request (store wins if both)
//   addr, wdata           byte address and store data
//   rdata                 load data, valid while ready=1 after a read
//   ready                 MEM stage may advance (freeze = ~ready)
//   SRAM_ADDR             SRAM word address
//   SRAM_DQ_O/_I/_OE      data pad out / in / output enable
//   SRAM_CE_N/_OE_N/_WE_N active-low SRAM strobes
module mem_stage_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned ADDR_W      = 18,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Mem_R_EN,
  input  logic              Mem_W_EN,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [31:0]       SRAM_DQ_O,
  input  logic [31:0]       SRAM_DQ_I,
  output logic              SRAM_DQ_OE,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_d, state_q;
  logic              op_write_d, op_write_q;
  logic [ADDR_W-1:0] sram_addr_d, sram_addr_q;
  logic [31:0]       dq_o_d, dq_o_q;
  logic [31:0]       rdata_d, rdata_q;

  logic             req;
  logic             start;
  logic             in_access;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  assign req       = Mem_R_EN | Mem_W_EN;
  assign start     = (state_q == IDLE) && req;
  assign in_access = (state_q == ACCESS);

  mem_wait_counter u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .en       (in_access),
    .load_val (LOAD_VAL),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Next-state, latches and ready.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_write_d  = op_write_q;
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;
    rdata_d     = rdata_q;
    ready       = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_d     = ACCESS;
          op_write_d  = Mem_W_EN;
          // Modulo-2^32 subtract; addresses below the base wrap into the
          // top of the SRAM rather than being rejected.
          sram_addr_d = ADDR_W'((addr - ADDR_BASE) >> 2);
          dq_o_d      = wdata;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          state_d = DONE;
          if (!op_write_q) begin
            rdata_d = SRAM_DQ_I;
          end
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the address/data latches are reset as well as the FSM, so the pads
  // and rdata come up at a known value instead of X until the first access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_write_q  <= 1'b0;
      sram_addr_q <= '0;
      dq_o_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_write_q  <= op_write_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      rdata_q     <= rdata_d;
    end
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset drops them immediately. WE_N rises in the last ACCESS cycle to
  // give the SRAM a data-hold cycle while DQ_OE is still driven.
  always_comb begin
    SRAM_CE_N  = STROBE_OFF;
    SRAM_OE_N  = STROBE_OFF;
    SRAM_WE_N  = STROBE_OFF;
    SRAM_DQ_OE = 1'b0;
    if (in_access) begin
      SRAM_CE_N = STROBE_ON;
      if (op_write_q) begin
        SRAM_DQ_OE = 1'b1;
        if (cnt != '0) begin
          SRAM_WE_N = STROBE_ON;
        end
      end else begin
        SRAM_OE_N = STROBE_ON;
      end
    end
  end

  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_DQ_O = dq_o_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl (WAIT_CYCLES=5, ADDR_BASE=1024).
// The stimulus pushes one expected transaction per request; the monitor
// accumulates strobe activity while ready is low and compares it against
// the queue head whenever ready rises (the DONE cycle).
module tb_mem_stage_sram_ctrl;

  typedef struct {
    logic [17:0] addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        is_write;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        Mem_R_EN;
  logic        Mem_W_EN;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [31:0] SRAM_DQ_O;
  logic [31:0] SRAM_DQ_I;
  logic        SRAM_DQ_OE;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;

  int   checks;
  int   failures;
  exp_t sb[$];
  logic [31:0] model_rdata;

  mem_stage_sram_ctrl #(
    .WAIT_CYCLES (5),
    .ADDR_W      (18),
    .ADDR_BASE   (32'd1024)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Mem_R_EN   (Mem_R_EN),
    .Mem_W_EN   (Mem_W_EN),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ_O  (SRAM_DQ_O),
    .SRAM_DQ_I  (SRAM_DQ_I),
    .SRAM_DQ_OE (SRAM_DQ_OE),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_OE_N  (SRAM_OE_N),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int   n_stall, n_ce, n_oe, n_we, n_dqoe, addr_bad, dq_bad;
  logic last_we_n;
  logic prev_ready;

  task automatic clear_acc();
    n_stall = 0; n_ce = 0; n_oe = 0; n_we = 0; n_dqoe = 0;
    addr_bad = 0; dq_bad = 0; last_we_n = 1'b0;
  endtask

  initial begin
    exp_t e;
    clear_acc();
    prev_ready = 1'b1;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        clear_acc();
        prev_ready = 1'b1;
      end else begin
        if (!ready) begin
          n_stall++;
          if (!SRAM_CE_N) begin
            n_ce++;
            last_we_n = SRAM_WE_N;
            if (sb.size() > 0 && SRAM_ADDR !== sb[0].addr) addr_bad++;
          end
          if (!SRAM_OE_N) n_oe++;
          if (!SRAM_WE_N) n_we++;
          if (SRAM_DQ_OE) begin
            n_dqoe++;
            if (sb.size() > 0 && SRAM_DQ_O !== sb[0].wdata) dq_bad++;
          end
        end else begin
          check("idle_strobes", {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 32'h0000_000E);
          if (!prev_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_done", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              check("stall_cycles", n_stall, 6);
              check("ce_cycles", n_ce, 5);
              check("addr_err", addr_bad, 0);
              check("rdata", rdata, e.rdata);
              if (e.is_write) begin
                check("wr_dqoe_cycles", n_dqoe, 5);
                check("wr_we_cycles", n_we, 4);
                check("wr_oe_cycles", n_oe, 0);
                check("wr_hold_we_n", {31'd0, last_we_n}, 32'd1);
                check("wr_dq_err", dq_bad, 0);
              end else begin
                check("rd_oe_cycles", n_oe, 5);
                check("rd_we_cycles", n_we, 0);
                check("rd_dqoe_cycles", n_dqoe, 0);
              end
            end
            clear_acc();
          end
        end
        prev_ready = ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_exp(input logic wr, input logic [17:0] exp_addr,
                          input logic [31:0] wd, input logic [31:0] di);
    exp_t e;
    e.is_write = wr;
    e.addr     = exp_addr;
    e.wdata    = wd;
    if (!wr) model_rdata = di;
    e.rdata    = model_rdata;
    sb.push_back(e);
  endtask

  // Wait for the DONE cycle, then step to the following IDLE cycle.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Called one time unit after a posedge, with the DUT in IDLE.
  task automatic issue(input string name, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] di,
                       input logic [17:0] exp_addr);
    Mem_R_EN  = rd;
    Mem_W_EN  = wr;
    addr      = a;
    wdata     = wd;
    SRAM_DQ_I = di;
    push_exp(wr, exp_addr, wd, di);
    wait_done(name);
  endtask

  task automatic go_idle();
    Mem_R_EN = 1'b0;
    Mem_W_EN = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    model_rdata = 32'd0;

    // 1. Reset held with a pending load.
    rst_n     = 1'b0;
    Mem_R_EN  = 1'b1;
    Mem_W_EN  = 1'b0;
    addr      = 32'h0000_040C;
    wdata     = 32'h0;
    SRAM_DQ_I = 32'hA5A5_0001;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 32'h0000_000E);
    check("rst_rdata", rdata, 32'h0);
    check("rst_sram_addr", {14'd0, SRAM_ADDR}, 32'h0);
    check("rst_dq_o", SRAM_DQ_O, 32'h0);
    push_exp(1'b0, 18'd3, 32'h0, 32'hA5A5_0001);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_access", {30'd0, SRAM_CE_N, SRAM_OE_N}, 32'h0);
    wait_done("t1");
    go_idle();
    @(posedge clk); #1;

    // 2. Read.
    issue("t2", 1'b1, 1'b0, 32'h0000_0408, 32'h0, 32'hDEAD_BEEF, 18'd2);
    go_idle();
    @(posedge clk); #1;

    // 3. Write.
    issue("t3", 1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 32'hFFFF_0000, 18'd0);
    go_idle();
    @(posedge clk); #1;

    // 4. Both enables: store wins, rdata untouched.
    issue("t4", 1'b1, 1'b1, 32'h0000_0404, 32'hCAFE_F00D, 32'h1111_1111, 18'd1);
    go_idle();
    @(posedge clk); #1;

    // 5. Back-to-back load, store, then idle. Address below base wraps.
    issue("t5a", 1'b1, 1'b0, 32'h0000_07FC, 32'h0, 32'h0BAD_F00D, 18'h000FF);
    issue("t5b", 1'b0, 1'b1, 32'h0000_03FC, 32'h55AA_55AA, 32'h0, 18'h3FFFF);
    go_idle();
    repeat (3) @(posedge clk);
    #1;

    // 6. Reset pulse in ACCESS cycle 3 of a write.
    Mem_R_EN = 1'b0;
    Mem_W_EN = 1'b1;
    addr     = 32'h0000_0410;
    wdata    = 32'h0F0F_0F0F;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_we", {30'd0, SRAM_WE_N, SRAM_DQ_OE}, 32'h1);
    Mem_W_EN = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 32'h0000_000E);
    check("abort_rdata", rdata, 32'h0);
    check("abort_idle_ready", {31'd0, ready}, 32'd1);
    model_rdata = 32'h0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_stays_idle", {31'd0, SRAM_CE_N}, 32'd1);

    // Read after the abort.
    issue("t7", 1'b1, 1'b0, 32'h0000_1400, 32'h0, 32'h600D_CAFE, 18'h00400);
    go_idle();
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
